vga_timing: RTL and testbench
=============================

# vga_timing

Free-running raster timing generator for the 1024x768 @ 60 Hz (XGA) video path, clocked from the 65 MHz pixel clock. It is the first stage of the draw pipeline and feeds hcount/vcount, sync and blanking directly into the background renderer, and from there into the sprite overlay stages. All outputs are registered, and the flags are cycle-aligned with the counters they describe.

## Interface
Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_SYNC_START, 1048, first hcount with hsync asserted
- H_SYNC_WIDTH, 136, hsync pulse length in pixels
- H_TOTAL, 1344, pixels per line, including blanking
- V_ACTIVE, 768, visible lines per frame
- V_SYNC_START, 771, first vcount with vsync asserted
- V_SYNC_WIDTH, 6, vsync pulse length in lines
- V_TOTAL, 806, lines per frame

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  synchronous, active-high reset
- hcount  out  11  current pixel column, 0..H_TOTAL-1
- vcount  out  11  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active-high (the top level applies the board polarity)
- vsync  out  1  vertical sync, active-high
- hblnk  out  1  horizontal blanking
- vblnk  out  1  vertical blanking
- frame_tick  out  1  one-cycle start-of-vblank pulse (present only with VGA_TIMING_FRAME_TICK_EN)

## Operation
- Horizontal counter: increments every clk. At H_TOTAL-1 it wraps to 0, and that wrap is the line-end event.
- Vertical counter: increments only on a line-end event. If vcount is V_TOTAL-1 on a line-end event, it wraps to 0.
- Frame wrap: (H_TOTAL-1, V_TOTAL-1) is followed by (0,0) on the next cycle.
- Flag decode, each a function of the counter values shown in the same cycle:
  - hblnk = hcount >= H_ACTIVE
  - hsync = H_SYNC_START <= hcount < H_SYNC_START+H_SYNC_WIDTH
  - vblnk = vcount >= V_ACTIVE
  - vsync = V_SYNC_START <= vcount < V_SYNC_START+V_SYNC_WIDTH
- Flag registration: flags are decoded from the next-state counter values and registered in the same edge as the counters, so that no flag skews against hcount/vcount.
- Arithmetic: all compares are unsigned at 11 bits. Parameters must satisfy ACTIVE < SYNC_START and SYNC_START+SYNC_WIDTH <= TOTAL <= 2047. Violations are caught by an elaboration-time check (simulation $error) and are not handled in hardware.
- No inputs besides clk and rst. The block never stalls.

## Timing
- Reset state: while rst is high at an edge, every output is 0: hcount=0, vcount=0, hsync=hblnk=vsync=vblnk=0, frame_tick=0.
- First cycle after reset: the first edge with rst low yields hcount=1, vcount=0.
- Reset mid-frame: takes effect at the next edge regardless of position, and counting restarts from (0,0). There is no partial-line recovery.
- Latency: zero between a counter value and its flags. Downstream stages add their own pipeline delay.
- Line period is H_TOTAL cycles; frame period is H_TOTAL*V_TOTAL cycles, which is 1 083 264 by default.
- Pulse lengths: hsync is high for exactly H_SYNC_WIDTH consecutive cycles per line. vsync is high for exactly V_SYNC_WIDTH*H_TOTAL consecutive cycles, rising on the cycle where vcount becomes V_SYNC_START (hcount=0).
- Simultaneous events: on the frame-wrap edge, the hblnk and vblnk falls happen in the same cycle.

## Configuration
- Macro: VGA_TIMING_FRAME_TICK_EN.
- Defined: the frame_tick port exists. It is high for exactly one cycle per frame, on the cycle where hcount=0 and vcount=V_ACTIVE, i.e. the first cycle of vblnk. It is registered like the other flags and cleared by rst. Game logic uses it as its once-per-frame update strobe.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package vga_pkg holds:
  - the XGA default constants (H_ACTIVE … V_TOTAL);
  - the counter width constant CNT_W=11, shared by every draw stage's hcount/vcount ports.
- Sub-module vga_counter: a parameterised modulo counter with enable, synchronous reset and registered wrap output. It is instantiated twice: horizontal with enable tied high, vertical enabled by the horizontal wrap. Flag decode stays in vga_timing.

## Test plan
- Reset: hold rst for 5 cycles, then release. All outputs read 0 during reset; the first post-release cycle shows hcount=1, vcount=0.
- Line sweep: observe one line. hblnk rises at hcount=1024; hsync is high for hcount 1048..1183 only (136 cycles); hcount=1343 is followed by hcount=0 with vcount incremented.
- Frame sweep: observe a full frame.
  - vblnk is high for vcount 768..805.
  - vsync is high for vcount 771..776 (6*1344 cycles).
  - (1343,805) is followed by (0,0).
  - Consecutive vsync rising edges are 1 083 264 cycles apart.
- Flag alignment: a scoreboard recomputes all four flags from hcount/vcount every cycle over 3 frames and reports zero mismatches.
- Mid-frame reset: assert rst at (500,400) for 1 cycle. Next cycle shows all outputs 0; the following cycle shows (1,0).
- With VGA_TIMING_FRAME_TICK_EN: frame_tick is high exactly once per frame, at (0,768), for 1 cycle. It stays 0 during and immediately after reset.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared draw-pipeline constants: XGA 1024x768@60 raster defaults and the
// counter width used on every stage's hcount/vcount ports.
package vga_pkg;

  localparam int unsigned CNT_W = 11;

  localparam int unsigned H_ACTIVE     = 1024;
  localparam int unsigned H_SYNC_START = 1048;
  localparam int unsigned H_SYNC_WIDTH = 136;
  localparam int unsigned H_TOTAL      = 1344;
  localparam int unsigned V_ACTIVE     = 768;
  localparam int unsigned V_SYNC_START = 771;
  localparam int unsigned V_SYNC_WIDTH = 6;
  localparam int unsigned V_TOTAL      = 806;

  // Half-open window test lo <= v < hi, unsigned at counter width.
  function automatic logic in_range(logic [CNT_W-1:0] v,
                                    logic [CNT_W-1:0] lo,
                                    logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing to the background renderer.
// frame_tick exists only when VGA_TIMING_FRAME_TICK_EN is defined.
interface vga_timing_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
`ifdef VGA_TIMING_FRAME_TICK_EN
  logic             frame_tick;
`endif

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk
`ifdef VGA_TIMING_FRAME_TICK_EN
    , output frame_tick
`endif
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk
`ifdef VGA_TIMING_FRAME_TICK_EN
    , input frame_tick
`endif
  );

endinterface

// File: rtl/vga_counter.sv
// Modulo-MODULUS counter with enable and synchronous reset. o_next exposes the
// value loaded at the coming edge; o_wrap is a registered "at last count" flag.
module vga_counter
  import vga_pkg::*;
#(
  parameter int unsigned MODULUS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_next,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_last;

  always_comb begin
    o_next = r_count;
    if (i_en) begin
      o_next = (r_count == LAST) ? '0 : r_count + CNT_W'(1);
    end
  end

  // Registering the terminal compare keeps the downstream enable path short.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_last  <= 1'b0;
    end else begin
      r_count <= o_next;
      r_last  <= (o_next == LAST);
    end
  end

  assign o_count = r_count;
  assign o_wrap  = r_last;

endmodule

// File: rtl/vga_timing.sv
// Free-running raster timing generator (XGA defaults). Flags are decoded from the
// next counter values so they register alongside hcount/vcount with no skew.
// Optional frame_tick output: define VGA_TIMING_FRAME_TICK_EN.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = vga_pkg::H_ACTIVE,
  parameter int unsigned H_SYNC_START = vga_pkg::H_SYNC_START,
  parameter int unsigned H_SYNC_WIDTH = vga_pkg::H_SYNC_WIDTH,
  parameter int unsigned H_TOTAL      = vga_pkg::H_TOTAL,
  parameter int unsigned V_ACTIVE     = vga_pkg::V_ACTIVE,
  parameter int unsigned V_SYNC_START = vga_pkg::V_SYNC_START,
  parameter int unsigned V_SYNC_WIDTH = vga_pkg::V_SYNC_WIDTH,
  parameter int unsigned V_TOTAL      = vga_pkg::V_TOTAL
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START + H_SYNC_WIDTH <= H_TOTAL &&
        H_TOTAL <= 2047 && V_ACTIVE < V_SYNC_START &&
        V_SYNC_START + V_SYNC_WIDTH <= V_TOTAL && V_TOTAL <= 2047)) begin : g_param_err
    $error("vga_timing: inconsistent raster parameters");
  end

  localparam logic [CNT_W-1:0] HA  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HSS = CNT_W'(H_SYNC_START);
  localparam logic [CNT_W-1:0] HSE = CNT_W'(H_SYNC_START + H_SYNC_WIDTH);
  localparam logic [CNT_W-1:0] VA  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VSS = CNT_W'(V_SYNC_START);
  localparam logic [CNT_W-1:0] VSE = CNT_W'(V_SYNC_START + V_SYNC_WIDTH);

  logic [CNT_W-1:0] w_h_cnt, w_h_next, w_v_cnt, w_v_next;
  logic             w_h_wrap, w_v_wrap;

  vga_counter #(.MODULUS(H_TOTAL)) u_hcnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (1'b1),
    .o_count (w_h_cnt),
    .o_next  (w_h_next),
    .o_wrap  (w_h_wrap)
  );

  vga_counter #(.MODULUS(V_TOTAL)) u_vcnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_h_wrap),
    .o_count (w_v_cnt),
    .o_next  (w_v_next),
    .o_wrap  (w_v_wrap)
  );

  logic r_hsync, r_vsync, r_hblnk, r_vblnk;
`ifdef VGA_TIMING_FRAME_TICK_EN
  logic r_frame_tick;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
      r_hblnk <= 1'b0;
      r_vblnk <= 1'b0;
`ifdef VGA_TIMING_FRAME_TICK_EN
      r_frame_tick <= 1'b0;
`endif
    end else begin
      r_hsync <= in_range(w_h_next, HSS, HSE);
      r_vsync <= in_range(w_v_next, VSS, VSE);
      r_hblnk <= (w_h_next >= HA);
      r_vblnk <= (w_v_next >= VA);
`ifdef VGA_TIMING_FRAME_TICK_EN
      r_frame_tick <= (w_h_next == '0) && (w_v_next == VA);
`endif
    end
  end

  // Last pixel of the last line must always land back on line 0.
  always_ff @(posedge clk) begin
    if (!rst && w_h_wrap && w_v_wrap) begin
      assert (w_v_next == '0);
    end
  end

  assign vga.hcount = w_h_cnt;
  assign vga.vcount = w_v_cnt;
  assign vga.hsync  = r_hsync;
  assign vga.vsync  = r_vsync;
  assign vga.hblnk  = r_hblnk;
  assign vga.vblnk  = r_vblnk;
`ifdef VGA_TIMING_FRAME_TICK_EN
  assign vga.frame_tick = r_frame_tick;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: one XGA-default instance for line timing and one
// reduced-raster instance so whole frames fit in a short run.
module tb_vga_timing;
  import vga_pkg::*;

  localparam int S_HA = 16, S_HSS = 18, S_HSW = 4, S_HT = 24;
  localparam int S_VA = 10, S_VSS = 12, S_VSW = 2, S_VT = 15;
  localparam int D_HA = 1024, D_HSS = 1048, D_HSW = 136, D_HT = 1344;
  localparam int D_VA = 768, D_VSS = 771, D_VSW = 6, D_VT = 806;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_if vga_d ();
  vga_timing_if vga_s ();

  vga_timing u_dut_def (
    .clk (clk),
    .rst (rst),
    .vga (vga_d)
  );

  vga_timing #(
    .H_ACTIVE (S_HA), .H_SYNC_START (S_HSS), .H_SYNC_WIDTH (S_HSW), .H_TOTAL (S_HT),
    .V_ACTIVE (S_VA), .V_SYNC_START (S_VSS), .V_SYNC_WIDTH (S_VSW), .V_TOTAL (S_VT)
  ) u_dut_small (
    .clk (clk),
    .rst (rst),
    .vga (vga_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_flags(int h, int v, int ha, int hss, int hsw,
                                           int va, int vss, int vsw);
    return {(h >= hss) && (h < hss + hsw), (v >= vss) && (v < vss + vsw),
            (h >= ha), (v >= va)};
  endfunction

  function automatic logic [31:0] pos(logic [10:0] v, logic [10:0] h);
    return 32'({v, h});
  endfunction

  logic [3:0] obs_s, obs_d;
  assign obs_s = {vga_s.hsync, vga_s.vsync, vga_s.hblnk, vga_s.vblnk};
  assign obs_d = {vga_d.hsync, vga_d.vsync, vga_d.hblnk, vga_d.vblnk};

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_pos"},   pos(vga_s.vcount, vga_s.hcount), 32'd0);
    chk({tag, "_s_flags"}, 32'(obs_s), 32'd0);
    chk({tag, "_d_pos"},   pos(vga_d.vcount, vga_d.hcount), 32'd0);
    chk({tag, "_d_flags"}, 32'(obs_d), 32'd0);
`ifdef VGA_TIMING_FRAME_TICK_EN
    chk({tag, "_tick"}, 32'(vga_s.frame_tick), 32'd0);
`endif
  endtask

  initial begin
    int mh, mv, dh, dv;
    int hb_rise, hs_cnt, hs_first, hs_last;
    int last_rise, n_rises, vs_run, vb_run;
    int tick_cnt;
    logic p_hblnk, p_vs, p_vb;
    logic found;

    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk_all_zero("rst");
    end
    rst = 1'b0;

    mh = 1; mv = 0; dh = 1; dv = 0;
    hb_rise = -1; hs_cnt = 0; hs_first = -1; hs_last = -1;
    last_rise = -1; n_rises = 0; vs_run = 0; vb_run = 0; tick_cnt = 0;
    p_hblnk = 1'b0; p_vs = 1'b0; p_vb = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("release_s_pos", pos(vga_s.vcount, vga_s.hcount), pos(11'd0, 11'd1));
        chk("release_d_pos", pos(vga_d.vcount, vga_d.hcount), pos(11'd0, 11'd1));
      end
      chk("s_pos", pos(vga_s.vcount, vga_s.hcount), pos(11'(mv), 11'(mh)));
      chk("s_flags", 32'(obs_s), 32'(exp_flags(mh, mv, S_HA, S_HSS, S_HSW, S_VA, S_VSS, S_VSW)));
      chk("d_pos", pos(vga_d.vcount, vga_d.hcount), pos(11'(dv), 11'(dh)));
      chk("d_flags", 32'(obs_d), 32'(exp_flags(dh, dv, D_HA, D_HSS, D_HSW, D_VA, D_VSS, D_VSW)));
`ifdef VGA_TIMING_FRAME_TICK_EN
      chk("s_tick", 32'(vga_s.frame_tick), 32'((mh == 0) && (mv == S_VA)));
      if (vga_s.frame_tick) tick_cnt++;
`endif
      if (mh == 0 && mv == 0)
        chk("s_frame_wrap", pos(vga_s.vcount, vga_s.hcount), 32'd0);
      if (dh == 0 && dv == 1)
        chk("d_line_wrap", pos(vga_d.vcount, vga_d.hcount), pos(11'd1, 11'd0));

      if (vga_d.hblnk && !p_hblnk && hb_rise < 0) hb_rise = int'(vga_d.hcount);
      p_hblnk = vga_d.hblnk;
      if (vga_d.hsync && dv == 0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(vga_d.hcount);
        hs_last = int'(vga_d.hcount);
      end

      if (vga_s.vsync && !p_vs) begin
        if (last_rise >= 0) chk("s_vsync_period", 32'(i - last_rise), 32'(S_HT * S_VT));
        last_rise = i;
        n_rises++;
        vs_run = 0;
      end
      if (vga_s.vsync) vs_run++;
      if (!vga_s.vsync && p_vs) chk("s_vsync_len", 32'(vs_run), 32'(S_VSW * S_HT));
      p_vs = vga_s.vsync;

      if (vga_s.vblnk && !p_vb) vb_run = 0;
      if (vga_s.vblnk) vb_run++;
      if (!vga_s.vblnk && p_vb) chk("s_vblnk_len", 32'(vb_run), 32'((S_VT - S_VA) * S_HT));
      p_vb = vga_s.vblnk;

      if (mh == S_HT - 1) begin
        mh = 0;
        mv = (mv == S_VT - 1) ? 0 : mv + 1;
      end else mh++;
      if (dh == D_HT - 1) begin
        dh = 0;
        dv = (dv == D_VT - 1) ? 0 : dv + 1;
      end else dh++;
    end

    chk("d_hblnk_rise", 32'(hb_rise), 32'd1024);
    chk("d_hsync_len", 32'(hs_cnt), 32'd136);
    chk("d_hsync_first", 32'(hs_first), 32'd1048);
    chk("d_hsync_last", 32'(hs_last), 32'd1183);
    chk("s_vsync_rises", 32'(n_rises), 32'd4);
`ifdef VGA_TIMING_FRAME_TICK_EN
    chk("s_tick_count", 32'(tick_cnt), 32'd4);
`endif

    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (vga_s.hcount == 11'd12 && vga_s.vcount == 11'd7) found = 1'b1;
    end
    chk("mid_pos_reached", 32'(found), 32'd1);

    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_s_pos", pos(vga_s.vcount, vga_s.hcount), pos(11'd0, 11'd1));
    chk("mid_rel_d_pos", pos(vga_d.vcount, vga_d.hcount), pos(11'd0, 11'd1));
    chk("mid_rel_s_flags", 32'(obs_s), 32'd0);
`ifdef VGA_TIMING_FRAME_TICK_EN
    chk("mid_rel_tick", 32'(vga_s.frame_tick), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
